// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage data-memory access sequencer with stall and fault reporting
//
// Runs one req/ack transaction per EX/MEM load or store against a
// variable-latency data memory and holds the upstream pipeline until it finishes.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   mem_read     MemRead from EX/MEM
//   mem_write    MemWrite from EX/MEM
//   addr         byte address (ALU result) from EX/MEM
//   wdata        store data from EX/MEM
//   flush        squash the op currently in EX/MEM (only looked at in IDLE)
//   dm_ack       memory completion pulse
//   dm_rdata     memory read data, valid with dm_ack
//   dm_req       memory request, held until ack or timeout
//   dm_we        1 = write, 0 = read; valid while dm_req
//   dm_addr      latched access address
//   dm_wdata     latched store data
//   stall        freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
//   rdata_out    load data to MEM/WB
//   rdata_valid  one-cycle pulse: successful load completed
//   fault        one-cycle pulse: access faulted
//   fault_code   00 none, 01 misaligned, 10 read+write, 11 timeout

module dmem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              flush,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rdata_valid,
    output logic              fault,
    output logic [1:0]        fault_code
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_MISALGN = 2'b01;
    localparam logic [1:0] FC_RDWR    = 2'b10;
    localparam logic [1:0] FC_TIMEOUT = 2'b11;

    // Last REQ cycle index before the access is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       op;

    assign op = (mem_read | mem_write) & ~flush;

    // Gated by reset so that asserting reset while an op sits in EX/MEM
    // releases the pipeline immediately rather than after the next edge.
    assign stall = reset & (((state == IDLE) & op) | (state == REQ));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            dm_req      <= 1'b0;
            dm_we       <= 1'b0;
            dm_addr     <= '0;
            dm_wdata    <= '0;
            rdata_out   <= '0;
            rdata_valid <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
        end else begin
            // Completion indicators are pulses that live only in DONE.
            rdata_valid <= 1'b0;
            fault       <= 1'b0;

            case (state)
                IDLE: begin
                    if (op) begin
                        if (mem_read && mem_write) begin
                            fault_code <= FC_RDWR;
                            fault      <= 1'b1;
                            state      <= DONE;
                        end else if (addr[1:0] != 2'b00) begin
                            fault_code <= FC_MISALGN;
                            fault      <= 1'b1;
                            state      <= DONE;
                        end else begin
                            dm_addr  <= addr;
                            dm_wdata <= wdata;
                            dm_we    <= mem_write;
                            cnt      <= 8'd0;
                            dm_req   <= 1'b1;
                            state    <= REQ;
                        end
                    end
                end

                REQ: begin
                    // Flush is deliberately not looked at here: once the
                    // request is on the bus the memory will act on it.
                    cnt <= cnt + 8'd1;
                    if (dm_ack) begin
                        dm_req     <= 1'b0;
                        fault_code <= FC_NONE;
                        if (!dm_we) begin
                            rdata_out   <= dm_rdata;
                            rdata_valid <= 1'b1;
                        end
                        state <= DONE;
                    end else if (cnt == TO_LAST) begin
                        dm_req     <= 1'b0;
                        fault_code <= FC_TIMEOUT;
                        fault      <= 1'b1;
                        state      <= DONE;
                    end
                end

                // One unstalled cycle lets EX/MEM load the next op; returning
                // to IDLE unconditionally prevents re-issuing the same one.
                DONE: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed scoreboard bench for dmem_access_ctrl

module tb_dmem_access_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, flush, dm_ack;
    logic [31:0] addr, wdata, dm_rdata;
    logic        dm_req, dm_we, stall, rdata_valid, fault;
    logic [31:0] dm_addr, dm_wdata, rdata_out;
    logic [1:0]  fault_code;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rv;
        logic [31:0] rd;
        logic        f;
        logic [1:0]  fc;
        int          stall_n;
        int          req_n;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_rd = 32'd0;
    logic [1:0]  m_fc = 2'd0;

    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .addr        (addr),
        .wdata       (wdata),
        .flush       (flush),
        .dm_ack      (dm_ack),
        .dm_rdata    (dm_rdata),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .stall       (stall),
        .rdata_out   (rdata_out),
        .rdata_valid (rdata_valid),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ack_at: REQ cycle (1-based) on which dm_ack is pulsed; 0 = never.
    task automatic run_op(input string name, input logic rd, input logic wr, input logic fl,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int ack_at, input logic [31:0] rdat);
        exp_t e;
        exp_t got;
        int   stall_n = 0;
        int   req_n   = 0;
        int   bad     = 0;
        logic done    = 1'b0;

        if (fl || !(rd || wr)) begin
            e = '{1'b0, m_rd, 1'b0, m_fc, 0, 0};
        end else if (rd && wr) begin
            m_fc = 2'b10;
            e = '{1'b0, m_rd, 1'b1, m_fc, 1, 0};
        end else if (a[1:0] != 2'b00) begin
            m_fc = 2'b01;
            e = '{1'b0, m_rd, 1'b1, m_fc, 1, 0};
        end else if (ack_at >= 1 && ack_at <= TO) begin
            m_fc = 2'b00;
            if (rd) m_rd = rdat;
            e = '{rd, m_rd, 1'b0, m_fc, 1 + ack_at, ack_at};
        end else begin
            m_fc = 2'b11;
            e = '{1'b0, m_rd, 1'b1, m_fc, 1 + TO, TO};
        end
        sb.push_back(e);

        @(posedge clk);
        #1;
        mem_read = rd; mem_write = wr; flush = fl; addr = a; wdata = wd;

        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (stall) begin
                stall_n++;
                if (dm_req) begin
                    req_n++;
                    if (dm_we !== wr || dm_addr !== a || dm_wdata !== wd) bad++;
                end
                dm_ack   = dm_req && (req_n == ack_at);
                dm_rdata = dm_ack ? rdat : $urandom;
            end else begin
                done = 1'b1;
            end
        end
        dm_ack = 1'b0;
        chk({name, ".completed"}, done, 1);

        got = sb.pop_front();
        chk({name, ".stall_cycles"}, stall_n, got.stall_n);
        chk({name, ".req_cycles"}, req_n, got.req_n);
        chk({name, ".req_fields_stable"}, bad, 0);
        chk({name, ".rdata_valid"}, rdata_valid, got.rv);
        chk({name, ".rdata_out"}, rdata_out, got.rd);
        chk({name, ".fault"}, fault, got.f);
        chk({name, ".fault_code"}, fault_code, got.fc);

        mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0; dm_ack = 1'b0;
        addr = '0; wdata = '0; dm_rdata = '0;

        #12;
        chk("rst.dm_req", dm_req, 0);
        chk("rst.stall", stall, 0);
        chk("rst.dm_addr", dm_addr, 0);
        chk("rst.rdata_valid", rdata_valid, 0);
        chk("rst.fault", fault, 0);
        chk("rst.fault_code", fault_code, 0);
        @(negedge clk);
        reset = 1'b1;

        run_op("load_fast", 1, 0, 0, 32'h40, 32'h0, 1, 32'hDEADBEEF);
        run_op("store4", 0, 1, 0, 32'h100, 32'h1234, 4, 32'h0);
        run_op("misaligned", 1, 0, 0, 32'h42, 32'h0, 1, 32'h0);
        run_op("load_after_mis", 1, 0, 0, 32'h48, 32'h0, 2, 32'h11223344);
        run_op("rd_wr", 1, 1, 0, 32'h50, 32'h9, 1, 32'h0);
        run_op("flushed", 1, 0, 1, 32'h60, 32'h0, 1, 32'h55);
        run_op("timeout", 1, 0, 0, 32'h70, 32'h0, 0, 32'h0);
        run_op("ack_last", 1, 0, 0, 32'h74, 32'h0, TO, 32'hA5A5F00D);
        run_op("store_mis", 0, 1, 0, 32'h103, 32'h77, 1, 32'h0);

        // Reset in the middle of an outstanding request.
        @(posedge clk);
        #1;
        mem_read = 1'b1; addr = 32'h80;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("midreq.req_before", dm_req, 1);
        reset = 1'b0;
        #1;
        chk("midreq.dm_req", dm_req, 0);
        chk("midreq.stall", stall, 0);
        chk("midreq.dm_addr", dm_addr, 0);
        chk("midreq.rdata_out", rdata_out, 0);
        chk("midreq.fault_code", fault_code, 0);
        mem_read = 1'b0; addr = '0;
        @(negedge clk);
        reset = 1'b1;
        m_rd = 32'd0; m_fc = 2'd0;

        // Stray ack while idle must change nothing.
        dm_ack = 1'b1; dm_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        dm_ack = 1'b0;
        chk("stray.stall", stall, 0);
        chk("stray.dm_req", dm_req, 0);
        chk("stray.rdata_valid", rdata_valid, 0);
        chk("stray.rdata_out", rdata_out, 0);
        chk("stray.fault", fault, 0);

        run_op("load_after_rst", 1, 0, 0, 32'h44, 32'h0, 2, 32'hCAFEF00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequences data-memory accesses for the MEM stage of the 5-stage pipeline. It takes the MemRead/MemWrite controls, ALU address and store data held in the EX/MEM pipeline register and runs a req/ack handshake with a variable-latency data memory. It drives a stall to freeze PC, IF/ID, ID/EX and EX/MEM until the access completes, and presents load data to MEM/WB. Misaligned accesses, illegal read+write combinations and memory timeouts are reported as faults.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 16, max cycles in REQ before abort (range 1..255)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
mem_read  input  1  load request from EX/MEM (MemRead)
mem_write  input  1  store request from EX/MEM (MemWrite)
addr  input  ADDR_W  ALU result from EX/MEM (byte address)
wdata  input  DATA_W  store data from EX/MEM (RDdata2)
flush  input  1  squash the op currently in EX/MEM
dm_ack  input  1  memory completion, single-cycle pulse
dm_rdata  input  DATA_W  memory read data, valid with dm_ack
dm_req  output  1  memory request, held until ack or timeout
dm_we  output  1  1 = write, 0 = read; valid while dm_req
dm_addr  output  ADDR_W  latched access address
dm_wdata  output  DATA_W  latched store data
stall  output  1  freeze upstream pipeline registers (combinational)
rdata_out  output  DATA_W  load data to MEM/WB
rdata_valid  output  1  one-cycle pulse, load data valid
fault  output  1  one-cycle pulse, access faulted
fault_code  output  2  00 none, 01 misaligned, 10 read+write, 11 timeout; held until next completion

Behaviour:
- Reset (reset==0, async): state=IDLE; dm_req, dm_we, dm_addr, dm_wdata, rdata_out, rdata_valid, fault and fault_code all 0. stall=0.
- States: IDLE, REQ, DONE (2-bit register).
- op = (mem_read|mem_write) & ~flush.
- IDLE:
  - op==0: stay in IDLE, stall=0.
  - op==1: stall=1 (combinational, same cycle).
  - Checks at the clock edge, in priority order:
    - mem_read&mem_write: fault_code=10, go to DONE, no dm_req.
    - addr[1:0]!=0: fault_code=01, go to DONE, no dm_req.
    - Otherwise: latch dm_addr=addr, dm_wdata=wdata, dm_we=mem_write; clear timeout counter; go to REQ.
- REQ:
  - dm_req=1, stall=1. Counter increments each cycle.
  - dm_ack==1: go to DONE.
    - Read: rdata_out<=dm_rdata.
    - Write: rdata_out unchanged.
    - fault_code<=00.
  - No ack and counter==TIMEOUT-1: fault_code<=11, go to DONE, dm_req drops.
  - Ack and timeout in the same cycle: the ack wins.
  - flush in REQ is ignored. An issued memory transaction is never aborted.
- DONE:
  - stall=0, dm_req=0. The pipeline advances one cycle and EX/MEM loads the next op.
  - rdata_valid=1 only if the completed access was a successful read.
  - fault=1 if fault_code!=00.
  - Always returns to IDLE next cycle, so the same op is never re-issued.
- Latency: op first seen in cycle 0. With ack in the first REQ cycle (cycle 1), DONE is in cycle 2: 2 stall cycles. In general stall cycles = 1 + cycles spent in REQ.
- A faulted op reaches DONE in cycle 1: 1 stall cycle.
- dm_ack outside REQ is ignored, with no state or data change.
- dm_addr, dm_wdata and dm_we remain stable for the whole of REQ.
- Reset asserted mid-REQ: dm_req drops immediately (async). No completion pulse is produced.

Test Plan:
- Load addr=0x40, ack on 1st REQ cycle with dm_rdata=0xDEADBEEF -> stall high 2 cycles, dm_req 1 cycle with dm_we=0 and dm_addr=0x40; DONE shows rdata_valid=1, rdata_out=0xDEADBEEF, fault=0.
- Store addr=0x100, wdata=0x1234, ack after 4 REQ cycles -> dm_req high 4 cycles with dm_we=1 and dm_wdata=0x1234; stall 5 cycles; rdata_valid stays 0.
- Load addr=0x42 -> no dm_req, stall 1 cycle, DONE: fault=1, fault_code=01. Next aligned load completes with fault_code=00.
- mem_read=mem_write=1 -> fault_code=10, no dm_req. Separately, with flush=1 and mem_read=1 -> stall stays 0 and no request is made.
- TIMEOUT=16, no ack -> dm_req high exactly 16 cycles, then fault pulse with fault_code=11. Ack arriving on the 16th cycle instead -> normal completion, fault_code=00.
- reset=0 asserted mid-REQ -> dm_req, stall and all outputs go to 0 immediately. After release, a stray dm_ack is ignored and the next load works normally.
